// File: rtl/uart_pixel_loader.sv
// UART receiver that packs three bytes per {R,G,B} pixel and writes a frame of NPIX pixels to RAM.
// Optional even-parity framing is enabled by defining LOADER_PARITY_EN.
module uart_pixel_loader #(
  parameter int unsigned DIVISOR   = 326,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned NPIX      = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 start,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [23:0]          mem_di,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err
);

  localparam int unsigned DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DW-1:0]        DIV_LAST = DW'(DIVISOR - 1);
  localparam logic [ADDR_BITS-1:0] PIX_LAST = ADDR_BITS'(NPIX - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic          rx_m, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bad, par_bad_n;
  logic          byte_ok, byte_bad;
  logic [1:0]    b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          div_cnt <= '0;
    else if (tick)      div_cnt <= '0;
    else                div_cnt <= div_cnt + 1'b1;
  end
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (cnt == 4'd7) begin
            cnt_n     = '0;
            bit_n     = '0;
            par_bad_n = 1'b0;
            state_n   = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      // cnt wraps 15->0, so each sample lands on every 16th tick after the start midpoint
      S_DATA: begin
        if (tick) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            shreg_n = {rx_s, shreg[7:1]};
            bit_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef LOADER_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            par_bad_n = (rx_s != ^shreg);
            state_n   = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            state_n = S_IDLE;
            if (rx_s && !par_bad) byte_ok  = 1'b1;
            else                  byte_bad = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Write strobe fires the cycle after the third byte; the address advance follows one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_di    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      b         <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start && !busy) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        frame_err <= 1'b0;
        mem_addr  <= '0;
        b         <= '0;
      end else begin
        if (mem_we) begin
          if (mem_addr == PIX_LAST) begin
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        if (byte_bad) begin
          frame_err <= 1'b1;
          b         <= '0;
        end else if (byte_ok && busy) begin
          unique case (b)
            2'd0:    begin mem_di[23:16] <= shreg; b <= 2'd1; end
            2'd1:    begin mem_di[15:8]  <= shreg; b <= 2'd2; end
            default: begin mem_di[7:0]   <= shreg; b <= 2'd0; mem_we <= 1'b1; end
          endcase
        end
      end
    end
  end

endmodule
